program_flash_responder: RTL and testbench

- Slave-side model/controller of one program-flash bank. It sits behind the chip-select, write-protect and address decode of the program address map.
- Accepts single-word read or program requests when its CS is asserted. It inserts a fixed number of wait states, then returns data, a one-cycle ready pulse, and an error flag.
- Instantiated twice in the flash subsystem: BASE=0x0000_0000 on CS0, BASE=0x0800_0000 on CS1.

---
 rtl/program_flash_responder_if.sv | 26 ++
 rtl/program_flash_responder.sv | 139 +++++++++++++
 tb/tb_program_flash_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/program_flash_responder_if.sv
// Request/response bundle between the program address map (master) and one
// program-flash bank responder (slave).
interface program_flash_responder_if #(
  parameter int N = 32
);
  logic         CS;
  logic         WP;
  logic [N-1:0] address;
  logic         rd_en;
  logic         wr_en;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         ready;
  logic         error;
  logic         busy;

  modport master (
    output CS, WP, address, rd_en, wr_en, wdata,
    input  rdata, ready, error, busy
  );

  modport slave (
    input  CS, WP, address, rd_en, wr_en, wdata,
    output rdata, ready, error, busy
  );
endinterface

// File: rtl/program_flash_responder.sv
// Single-word program-flash bank responder with fixed wait states.
// Define FLASH_AND_PROGRAM_EN to make programming AND-only (NOR-style bit clearing).
module program_flash_responder #(
  parameter int           N           = 32,
  parameter logic [N-1:0] BASE        = '0,
  parameter logic [N-1:0] BANK_BYTES  = N'(32'h0800_0000),
  parameter int           DEPTH       = 256,
  parameter int           WAIT_STATES = 2
) (
  input  logic                       clk,
  input  logic                       nRESET,
  program_flash_responder_if.slave   bus
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic           wr_q;
  logic           err_q;
  logic [AW-1:0]  idx_q;
  logic [N-1:0]   wdata_q;
  logic [N-1:0]   rdata_q;
  logic           ready_q;
  logic           error_q;
  logic           busy_q;

  // The array itself is never reset; a per-word programmed flag makes every
  // word read as erased after reset.
  logic [N-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [N-1:0]  offset;
  logic          accept;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  always_comb begin
    offset  = bus.address - BASE;
    accept  = (state_q == S_IDLE) && bus.CS && (bus.rd_en || bus.wr_en);
    acc_err = (bus.rd_en && bus.wr_en) || (bus.address[1:0] != 2'b00) ||
              (offset >= BANK_BYTES) || (bus.wr_en && bus.WP);
    acc_idx = offset[AW+1:2];
  end

  // Everything that happens on the edge entering RESP, sourced either from the
  // latched request or, with zero wait states, straight from the accepting cycle.
  logic          resp_go;
  logic          go_wr;
  logic          go_err;
  logic [AW-1:0] go_idx;
  logic [N-1:0]  go_wdata;
  logic [N-1:0]  cur_word;
  logic [N-1:0]  mem_wdata;
  logic          mem_we;

  always_comb begin
    resp_go  = 1'b0;
    go_wr    = wr_q;
    go_err   = err_q;
    go_idx   = idx_q;
    go_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      resp_go  = accept && (WS == 4'd0);
      go_wr    = bus.wr_en;
      go_err   = acc_err;
      go_idx   = acc_idx;
      go_wdata = bus.wdata;
    end else if (state_q == S_WAIT) begin
      resp_go = (cnt_q == WS);
    end
    cur_word = valid_q[go_idx] ? mem_q[go_idx] : {N{1'b1}};
`ifdef FLASH_AND_PROGRAM_EN
    mem_wdata = cur_word & go_wdata;
`else
    mem_wdata = go_wdata;
`endif
    mem_we = resp_go && go_wr && !go_err;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wr_q    <= bus.wr_en;
            err_q   <= acc_err;
            idx_q   <= acc_idx;
            wdata_q <= bus.wdata;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (WS == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (resp_go) state_q <= S_RESP;
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (resp_go) begin
        ready_q <= 1'b1;
        error_q <= go_err;
        if (!go_wr && !go_err) rdata_q <= cur_word;
      end
      if (mem_we) valid_q[go_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[go_idx] <= mem_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.error = error_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_program_flash_responder.sv
// Directed plus randomized bench for program_flash_responder (BASE=0x0800_0000)
// against a word-array reference model.
module tb_program_flash_responder;

  localparam logic [31:0] BASE  = 32'h0800_0000;
  localparam logic [31:0] BANK  = 32'h0800_0000;
  localparam int          WS    = 2;
  localparam int          DEPTH = 256;

  logic clk;
  logic nRESET;

  program_flash_responder_if #(.N(32)) bus();

  program_flash_responder #(
    .N(32), .BASE(BASE), .BANK_BYTES(BANK), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .nRESET(nRESET),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_erase();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic xact(input bit rd, input bit wr, input bit wp,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input bit drop_cs, input bit noise, input string tag);
    logic [31:0] off;
    bit          exp_err;
    int          idx;
    int          lat;
    off     = addr - BASE;
    exp_err = (rd && wr) || (addr[1:0] != 2'b00) || (off >= BANK) || (wr && wp);
    idx     = int'((off / 4) % DEPTH);
    if (!exp_err) begin
      if (wr) begin
`ifdef FLASH_AND_PROGRAM_EN
        model_mem[idx] = model_mem[idx] & wd;
`else
        model_mem[idx] = wd;
`endif
      end else begin
        model_rdata = model_mem[idx];
      end
    end

    @(negedge clk);
    bus.CS = 1'b1; bus.WP = wp; bus.address = addr;
    bus.rd_en = rd; bus.wr_en = wr; bus.wdata = wd;
    @(posedge clk); #1;
    bus.CS    = !drop_cs;
    bus.rd_en = noise;
    bus.wr_en = noise && ($urandom_range(0, 1) == 1);
    bus.WP    = noise && ($urandom_range(0, 1) == 1);
    if (noise) begin
      bus.address = $urandom;
      bus.wdata   = $urandom;
    end
    chk({tag, "_busy_accept"}, 32'(bus.busy), 32'd1);

    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.ready) chk({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
    end while (!bus.ready && lat < 12);

    chk({tag, "_latency"}, 32'(lat), 32'(WS + 1));
    chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
    chk({tag, "_rdata"}, bus.rdata, model_rdata);
    chk({tag, "_busy_resp"}, 32'(bus.busy), 32'd1);
    $display("xact %s rd=%0b wr=%0b wp=%0b addr=%h wdata=%h -> lat=%0d error=%0b rdata=%h",
             tag, rd, wr, wp, addr, wd, lat, bus.error, bus.rdata);
    bus.CS = 1'b0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.WP = 1'b0;

    @(posedge clk); #1;
    chk({tag, "_ready_pulse"}, 32'(bus.ready), 32'd0);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit          saw;
    int          kind;
    bit          rd;
    bit          wr;
    logic [31:0] addr;

    model_erase();
    model_rdata = 32'h0;
    bus.CS = 1'b0; bus.WP = 1'b0; bus.address = '0;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wdata = '0;
    nRESET = 1'b0;
    #2;
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_error", 32'(bus.error), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    #3 nRESET = 1'b1;

    xact(1, 0, 0, 32'h0800_0BCC, 32'h0, 0, 0, "read_erased");
    xact(1, 0, 0, 32'h0800_0BCD, 32'h0, 0, 0, "misaligned");
    xact(1, 0, 0, 32'h2000_0DEF, 32'h0, 0, 0, "out_of_range");
    xact(1, 0, 0, 32'h0000_0BCC, 32'h0, 0, 0, "below_base");
    xact(0, 1, 1, 32'h0800_0CB8, 32'h1234_5678, 0, 0, "wp_write");
    xact(1, 0, 0, 32'h0800_0CB8, 32'h0, 0, 0, "wp_readback");
    xact(0, 1, 0, 32'h0800_0CB8, 32'h1234_5678, 0, 0, "prog1");
    xact(0, 1, 0, 32'h0800_0CB8, 32'hFF00_FFFF, 0, 0, "prog2");
    xact(1, 0, 0, 32'h0800_0CB8, 32'h0, 0, 0, "prog_readback");
    xact(0, 1, 0, 32'h0800_0000, 32'hA5A5_A5A5, 0, 0, "alias_write");
    xact(1, 0, 0, 32'h0800_0400, 32'h0, 0, 0, "alias_read");
    xact(1, 1, 0, 32'h0800_0100, 32'h0, 0, 0, "rd_and_wr");
    xact(1, 0, 0, 32'h0800_0CB8, 32'h0, 1, 0, "cs_drop");
    xact(1, 0, 0, 32'h0800_0000, 32'h0, 0, 1, "busy_noise");

    // Abort a program operation with a reset during its wait states.
    @(negedge clk);
    bus.CS = 1'b1; bus.wr_en = 1'b1; bus.WP = 1'b0;
    bus.address = BASE + 32'h10; bus.wdata = 32'h0;
    @(posedge clk); #1;
    bus.CS = 1'b0; bus.wr_en = 1'b0;
    @(posedge clk); #2;
    nRESET = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_error", 32'(bus.error), 32'd0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    saw = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (bus.ready) saw = 1'b1; end
    @(negedge clk) nRESET = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (bus.ready) saw = 1'b1; end
    chk("midrst_no_ready", 32'(saw), 32'd0);
    $display("xact midrst aborted write addr=%h ready_seen=%0b", BASE + 32'h10, saw);
    model_erase();
    model_rdata = 32'h0;
    xact(1, 0, 0, BASE + 32'h10, 32'h0, 0, 0, "midrst_read");
    xact(1, 0, 0, 32'h0800_0CB8, 32'h0, 0, 0, "midrst_read2");

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      rd   = ($urandom_range(0, 1) == 1);
      wr   = !rd;
      addr = BASE + {20'h0, 10'($urandom_range(0, 511)), 2'b00};
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 1) addr = $urandom;
      if (kind == 2) begin rd = 1'b1; wr = 1'b1; end
      xact(rd, wr, kind == 3, addr, $urandom, kind == 4, kind == 5, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
